// File: rtl/fpu_muldiv_sequencer_if.sv
// Handshake and core-side bundle for the FP multiply/divide issue/collect sequencer.
// The sequencer takes the slave view; the requester/core/consumer environment takes the master view.
interface fpu_muldiv_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        in_op;
    logic        core_start;
    logic [15:0] core_x;
    logic [15:0] core_y;
    logic        core_op;
    logic        core_done;
    logic [1:0]  core_ofuf;
    logic [15:0] core_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [1:0]  out_ofuf;
    logic        out_timeout;

    modport slave (
        input  in_valid, in_x, in_y, in_op, core_done, core_ofuf, core_result, out_ready,
        output in_ready, core_start, core_x, core_y, core_op, out_valid, out_result, out_ofuf,
        output out_timeout
    );

    modport master (
        output in_valid, in_x, in_y, in_op, core_done, core_ofuf, core_result, out_ready,
        input  in_ready, core_start, core_x, core_y, core_op, out_valid, out_result, out_ofuf,
        input  out_timeout
    );
endinterface

// File: rtl/fpu_muldiv_sequencer.sv
// Issue/collect stage for the 16-bit FP multiply/divide core: loads one op, waits for done
// (or times out), converts OFUF into a final half-precision encoding and holds it until consumed.
module fpu_muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    fpu_muldiv_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             sign_r;
    logic [15:0]      core_x_r;
    logic [15:0]      core_y_r;
    logic             core_op_r;
    logic             out_valid_r;
    logic [15:0]      out_result_r;
    logic [1:0]       out_ofuf_r;
    logic             out_timeout_r;
    logic [17:0]      fmt_s;
    logic             limit_s;

    // Returns {ofuf, result}: overflow (and the unused 11 code) becomes signed inf, underflow signed zero.
    function automatic logic [17:0] format_result(input logic sign, input logic [1:0] ofuf,
                                                  input logic [15:0] res);
        logic [17:0] f;
        case (ofuf)
            2'b00:   f = {2'b00, res};
            2'b01:   f = {2'b01, sign, 15'h0000};
            2'b10:   f = {2'b10, sign, 5'h1F, 10'h000};
            2'b11:   f = {2'b10, sign, 5'h1F, 10'h000};
            default: f = {2'b10, sign, 5'h1F, 10'h000};
        endcase
        return f;
    endfunction

    assign fmt_s   = format_result(sign_r, bus.core_ofuf, bus.core_result);
    assign limit_s = (cnt_r == CNT_LIMIT);

    // Next-state decode; done is checked before the timeout limit so a late done still wins.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: state_s = WAIT;
            WAIT: begin
                if (bus.core_done || limit_s) begin
                    state_s = HOLD;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, operand latches, wait counter and the held output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            sign_r        <= 1'b0;
            core_x_r      <= 16'h0000;
            core_y_r      <= 16'h0000;
            core_op_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            out_result_r  <= 16'h0000;
            out_ofuf_r    <= 2'b00;
            out_timeout_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        core_x_r  <= bus.in_x;
                        core_y_r  <= bus.in_y;
                        core_op_r <= bus.in_op;
                        sign_r    <= bus.in_x[15] ^ bus.in_y[15];
                    end
                end
                LOAD: cnt_r <= {CNT_W{1'b0}};
                WAIT: begin
                    if (bus.core_done) begin
                        out_result_r  <= fmt_s[15:0];
                        out_ofuf_r    <= fmt_s[17:16];
                        out_timeout_r <= 1'b0;
                        out_valid_r   <= 1'b1;
                    end else if (limit_s) begin
                        out_result_r  <= 16'h7E00;
                        out_ofuf_r    <= 2'b11;
                        out_timeout_r <= 1'b1;
                        out_valid_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    // Block reset doubles as a core reset so a dropped op cannot leak a stale done.
    assign bus.core_start  = reset | (state_r == LOAD);
    assign bus.in_ready    = (state_r == IDLE);
    assign bus.core_x      = core_x_r;
    assign bus.core_y      = core_y_r;
    assign bus.core_op     = core_op_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = out_result_r;
    assign bus.out_ofuf    = out_ofuf_r;
    assign bus.out_timeout = out_timeout_r;

endmodule

// File: tb/tb_fpu_muldiv_sequencer.sv
// Directed bench for fpu_muldiv_sequencer: the core is emulated by hand-timed done/result drives.
module tb_fpu_muldiv_sequencer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    fpu_muldiv_sequencer_if bus ();

    fpu_muldiv_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_x = 16'h0; bus.in_y = 16'h0; bus.in_op = 1'b0;
        bus.core_done = 1'b0; bus.core_ofuf = 2'b00; bus.core_result = 16'h0; bus.out_ready = 1'b0;
        tick(); tick();
        n_cmp++;
        if (bus.core_start !== 1'b1) begin
            n_bad++; $display("FAIL rst_core_start got=%b exp=1", bus.core_start);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.out_result, bus.out_ofuf, bus.out_timeout,
             bus.core_x, bus.core_y, bus.core_op, bus.core_start} !== {1'b1, 1'b0, 16'h0, 2'b00,
             1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_state rdy=%b ov=%b res=%h of=%b to=%b cx=%h cy=%h cop=%b cs=%b",
                     bus.in_ready, bus.out_valid, bus.out_result, bus.out_ofuf, bus.out_timeout,
                     bus.core_x, bus.core_y, bus.core_op, bus.core_start);
        end
    endtask

    // One full op: core_done rises after `dly` WAIT cycles; checks load, latency and formatting.
    task automatic run_op(input string nm, input logic [15:0] x, input logic [15:0] y,
                          input logic op, input int dly, input logic [15:0] cres,
                          input logic [1:0] cof, input logic [15:0] exp_res,
                          input logic [1:0] exp_of);
        bit early;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s_ready got=%b exp=1", nm, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_x = x; bus.in_y = y; bus.in_op = op;
        bus.core_done = 1'b0;
        tick();
        bus.in_valid = 1'b0; bus.in_x = 16'hDEAD; bus.in_y = 16'hBEEF;
        n_cmp++;
        if ({bus.core_start, bus.core_x, bus.core_y, bus.core_op, bus.in_ready} !==
            {1'b1, x, y, op, 1'b0}) begin
            n_bad++;
            $display("FAIL %s_load cs=%b cx=%h cy=%h cop=%b rdy=%b exp cs=1 cx=%h cy=%h cop=%b rdy=0",
                     nm, bus.core_start, bus.core_x, bus.core_y, bus.core_op, bus.in_ready, x, y, op);
        end
        tick();
        early = 1'b0;
        for (int i = 0; i < dly; i++) begin
            if (bus.out_valid !== 1'b0 || bus.core_start !== 1'b0) early = 1'b1;
            tick();
        end
        n_cmp++;
        if (early || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s_wait out_valid/core_start active during WAIT got=1 exp=0", nm);
        end
        bus.core_done = 1'b1; bus.core_result = cres; bus.core_ofuf = cof;
        tick();
        n_cmp++;
        if ({bus.out_valid, bus.out_result, bus.out_ofuf, bus.out_timeout} !==
            {1'b1, exp_res, exp_of, 1'b0}) begin
            n_bad++;
            $display("FAIL %s_result ov=%b res=%h of=%b to=%b exp ov=1 res=%h of=%b to=0",
                     nm, bus.out_valid, bus.out_result, bus.out_ofuf, bus.out_timeout, exp_res, exp_of);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0; bus.core_done = 1'b0;
        n_cmp++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL %s_release ov=%b rdy=%b exp ov=0 rdy=1", nm, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_formats();
        run_op("mul_ok",   16'h4000, 16'h4200, 1'b0, 5, 16'h4600, 2'b00, 16'h4600, 2'b00);
        run_op("div_zero", 16'hC000, 16'h0000, 1'b1, 3, 16'h1234, 2'b10, 16'hFC00, 2'b10);
        run_op("mul_uf",   16'h8400, 16'h0400, 1'b0, 2, 16'h1234, 2'b01, 16'h8000, 2'b01);
        run_op("of11",     16'h3C00, 16'h3C00, 1'b0, 0, 16'h5555, 2'b11, 16'h7C00, 2'b10);
        run_op("done_lim", 16'hBC00, 16'h4000, 1'b1, 63, 16'hB800, 2'b00, 16'hB800, 2'b00);
    endtask

    task automatic test_timeout();
        int n;
        bus.in_valid = 1'b1; bus.in_x = 16'h4400; bus.in_y = 16'h4400; bus.in_op = 1'b1;
        bus.core_done = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (bus.out_valid === 1'b1) break;
        end
        n_cmp++;
        if (n !== 64) begin
            n_bad++; $display("FAIL to_latency got=%0d exp=64", n);
        end
        n_cmp++;
        if ({bus.out_valid, bus.out_result, bus.out_ofuf, bus.out_timeout} !==
            {1'b1, 16'h7E00, 2'b11, 1'b1}) begin
            n_bad++;
            $display("FAIL to_result ov=%b res=%h of=%b to=%b exp ov=1 res=7e00 of=11 to=1",
                     bus.out_valid, bus.out_result, bus.out_ofuf, bus.out_timeout);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        run_op("after_to", 16'h4000, 16'h4000, 1'b0, 4, 16'h4400, 2'b00, 16'h4400, 2'b00);
    endtask

    // Stall the consumer, poke in_valid during HOLD and across the output handshake cycle.
    task automatic test_hold();
        bit bad;
        bus.in_valid = 1'b1; bus.in_x = 16'h4200; bus.in_y = 16'h3800; bus.in_op = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.core_done = 1'b1; bus.core_result = 16'h3E00; bus.core_ofuf = 2'b00;
        tick();
        bus.core_result = 16'h0000; bus.core_ofuf = 2'b10;
        bus.in_valid = 1'b1; bus.in_x = 16'h1111; bus.in_y = 16'h2222;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if ({bus.out_valid, bus.out_result, bus.out_ofuf, bus.out_timeout, bus.in_ready,
                 bus.core_x, bus.core_start} !== {1'b1, 16'h3E00, 2'b00, 1'b0, 1'b0, 16'h4200, 1'b0})
                bad = 1'b1;
            tick();
        end
        n_cmp++;
        if (bad) begin
            n_bad++; $display("FAIL hold_stable output/in_ready/core_x changed while stalled exp res=3e00");
        end
        bus.core_done = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++;
        if ({bus.out_valid, bus.in_ready, bus.core_start, bus.core_x} !== {1'b0, 1'b1, 1'b0, 16'h4200}) begin
            n_bad++;
            $display("FAIL hold_release ov=%b rdy=%b cs=%b cx=%h exp ov=0 rdy=1 cs=0 cx=4200",
                     bus.out_valid, bus.in_ready, bus.core_start, bus.core_x);
        end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if ({bus.core_start, bus.core_x} !== {1'b1, 16'h1111}) begin
            n_bad++;
            $display("FAIL hold_next_accept cs=%b cx=%h exp cs=1 cx=1111", bus.core_start, bus.core_x);
        end
    endtask

    // Continues the op accepted by test_hold: reset it mid-WAIT and confirm it vanishes.
    task automatic test_reset_mid();
        bit seen;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.core_start !== 1'b1) begin
            n_bad++; $display("FAIL mid_core_start got=%b exp=1", bus.core_start);
        end
        tick();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.core_x, bus.out_result} !== {1'b1, 1'b0, 16'h0, 16'h0}) begin
            n_bad++;
            $display("FAIL mid_reset rdy=%b ov=%b cx=%h res=%h exp rdy=1 ov=0 cx=0 res=0",
                     bus.in_ready, bus.out_valid, bus.core_x, bus.out_result);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.core_start !== 1'b0 || bus.in_ready !== 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++; $display("FAIL mid_dropped activity after reset got=1 exp=0");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_formats();
        test_timeout();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
